// File: rtl/rand_test_pkg.sv
// Shared types and default constants for the random range generator and its
// histogram self-test, so both ends agree on bin count, run length and tolerance.
package rand_test_pkg;

    // Checker run phases.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ACCUM = 3'd2,
        EVAL  = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam int DEF_NBINS       = 7;
    localparam int DEF_SAMPLE_LOG2 = 10;
    localparam int DEF_TOL         = 32;

endpackage

// File: rtl/rand_hist_checker_if.sv
// Control, sample and readout signals between the checker and its user.
interface rand_hist_checker_if #(
    parameter int CNT_W = rand_test_pkg::DEF_SAMPLE_LOG2 + 1
);
    logic             start;
    logic             sample_valid;
    logic [2:0]       sample;
    logic [2:0]       rd_addr;
    logic             busy;
    logic             done;
    logic             pass;
    logic             range_err;
    logic [CNT_W-1:0] max_count;
    logic [CNT_W-1:0] min_count;
    logic [CNT_W-1:0] rd_count;

    // Generator / readout side.
    modport master (
        output start, sample_valid, sample, rd_addr,
        input  busy, done, pass, range_err, max_count, min_count, rd_count
    );

    // Checker side.
    modport slave (
        input  start, sample_valid, sample, rd_addr,
        output busy, done, pass, range_err, max_count, min_count, rd_count
    );
endinterface

// File: rtl/rand_hist_bins.sv
// Bank of NBINS histogram counters with parallel clear, single-bin increment
// and two combinational read ports (evaluation pointer and external readout).
module rand_hist_bins #(
    parameter int NBINS = rand_test_pkg::DEF_NBINS,
    parameter int CNT_W = rand_test_pkg::DEF_SAMPLE_LOG2 + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             inc_en_i,
    input  logic [2:0]       inc_addr_i,
    input  logic [2:0]       eval_addr_i,
    input  logic [2:0]       rd_addr_i,
    output logic [CNT_W-1:0] eval_count_o,
    output logic [CNT_W-1:0] rd_count_o
);

    logic [CNT_W-1:0] bin_q [NBINS];

    // Counter bank: reset/clear all bins, otherwise bump the addressed bin.
    // NOTE: the bins are reset explicitly because the readout port must show
    // zeros straight after reset; a plain RAM without reset would not.
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NBINS; i++) bin_q[i] <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < NBINS; i++) bin_q[i] <= '0;
        end else if (inc_en_i) begin
            for (int i = 0; i < NBINS; i++) begin
                if (inc_addr_i == 3'(i)) bin_q[i] <= bin_q[i] + CNT_W'(1);
            end
        end
    end

    // Read muxes; addresses with no bin behind them read as zero.
    // NOTE: outputs get a default before the loop so no path leaves them
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        eval_count_o = '0;
        rd_count_o   = '0;
        for (int i = 0; i < NBINS; i++) begin
            if (eval_addr_i == 3'(i)) eval_count_o = bin_q[i];
            if (rd_addr_i == 3'(i))   rd_count_o   = bin_q[i];
        end
    end

endmodule

// File: rtl/rand_hist_checker.sv
// Histogram-based uniformity self-test: collects 2^SAMPLE_LOG2 samples into
// NBINS bins, then scans the bins for the max/min spread and flags pass/fail.
module rand_hist_checker
    import rand_test_pkg::*;
#(
    parameter int NBINS       = DEF_NBINS,
    parameter int SAMPLE_LOG2 = DEF_SAMPLE_LOG2,
    parameter int CNT_W       = SAMPLE_LOG2 + 1,
    parameter int TOL         = DEF_TOL
) (
    input  logic               qzt_clk,
    input  logic               reset,
    rand_hist_checker_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'((1 << SAMPLE_LOG2) - 1);
    localparam logic [2:0]       LAST_BIN    = 3'(NBINS - 1);
    localparam logic [3:0]       NBINS_W     = 4'(NBINS);
    localparam logic [CNT_W-1:0] TOL_W       = CNT_W'(TOL);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [2:0]       eval_idx_q, eval_idx_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [CNT_W-1:0] min_q, min_d;
    logic             range_err_q, range_err_d;
    logic             pass_q, pass_d;

    logic             bins_clear;
    logic             bins_inc;
    logic             sample_in_range;
    logic [CNT_W-1:0] eval_count;

    assign sample_in_range = ({1'b0, bus.sample} < NBINS_W);

    rand_hist_bins #(
        .NBINS (NBINS),
        .CNT_W (CNT_W)
    ) u_bins (
        .clk_i        (qzt_clk),
        .rst_i        (reset),
        .clear_i      (bins_clear),
        .inc_en_i     (bins_inc),
        .inc_addr_i   (bus.sample),
        .eval_addr_i  (eval_idx_q),
        .rd_addr_i    (bus.rd_addr),
        .eval_count_o (eval_count),
        .rd_count_o   (bus.rd_count)
    );

    // State and result registers; reset aborts any run back to IDLE.
    always_ff @(posedge qzt_clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            eval_idx_q   <= '0;
            max_q        <= '0;
            min_q        <= '1;
            range_err_q  <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            eval_idx_q   <= eval_idx_d;
            max_q        <= max_d;
            min_q        <= min_d;
            range_err_q  <= range_err_d;
            pass_q       <= pass_d;
        end
    end

    // Next-state and datapath control for the clear/accumulate/evaluate run.
    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        eval_idx_d   = eval_idx_q;
        max_d        = max_q;
        min_d        = min_q;
        range_err_d  = range_err_q;
        pass_d       = pass_q;
        bins_clear   = 1'b0;
        bins_inc     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) state_d = CLEAR;
            end
            CLEAR: begin
                bins_clear   = 1'b1;
                sample_cnt_d = '0;
                eval_idx_d   = '0;
                max_d        = '0;
                min_d        = '1;
                range_err_d  = 1'b0;
                pass_d       = 1'b0;
                state_d      = ACCUM;
            end
            ACCUM: begin
                if (bus.sample_valid) begin
                    sample_cnt_d = sample_cnt_q + CNT_W'(1);
                    if (sample_in_range) bins_inc    = 1'b1;
                    else                 range_err_d = 1'b1;
                    if (sample_cnt_q == LAST_SAMPLE) state_d = EVAL;
                end
            end
            EVAL: begin
                max_d      = (eval_count > max_q) ? eval_count : max_q;
                min_d      = (eval_count < min_q) ? eval_count : min_q;
                eval_idx_d = eval_idx_q + 3'd1;
                if (eval_idx_q == LAST_BIN) begin
                    // Judge on the values that include the final bin.
                    pass_d  = ((max_d - min_d) <= TOL_W) && !range_err_q;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy      = (state_q == CLEAR) || (state_q == ACCUM) || (state_q == EVAL);
    assign bus.done      = (state_q == DONE);
    assign bus.pass      = pass_q;
    assign bus.range_err = range_err_q;
    assign bus.max_count = max_q;
    assign bus.min_count = min_q;

endmodule
